// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
//   div_arb_state_t : arbiter FSM state encoding
//   DIV_ZERO_Q      : quotient returned for a zero divisor; the divider is skipped
//   OPND_W / QUOT_W : operand and quotient widths
package divider_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } div_arb_state_t;

    localparam logic [7:0]  DIV_ZERO_Q = 8'hFF;
    localparam int unsigned OPND_W     = 16;
    localparam int unsigned QUOT_W     = 8;

endpackage

// File: rtl/divider_arbiter_rr_pick.sv
// Round-robin first-one finder.
// Starting at ptr and wrapping, it returns the first set bit of req.
//   req   in  N_REQ  request vector
//   ptr   in  ID_W   highest-priority position this round
//   grant out N_REQ  one-hot grant (all zero when no request is set)
//   id    out ID_W   index of the granted bit
//   any   out 1      at least one request is set
module divider_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            // ptr < N_REQ and k < N_REQ, so one conditional subtract is enough to wrap
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin scheduler that shares one external sequential divider among N_REQ requesters.
// For each request it accepts a (dividend, divisor) pair, starts the divider, and waits the
// fixed divider latency. It then returns the 8-bit quotient, tagged with the requester id.
//   clk, nRst      clock and synchronous active-high reset
//   req_valid      per-requester pending flag; operands are held until accepted
//   req_dividend   packed dividends, requester i at [16*i +: 16]
//   req_divisor    packed divisors, requester i at [16*i +: 16]
//   req_ready      one-hot accept, combinational from IDLE state and req_valid
//   resp_valid     one-cycle response strobe with resp_id / resp_quotient
//   busy           high whenever the FSM is not IDLE
//   div_en         one-cycle divider start, only in ISSUE
//   div_dividend   latched operand for the divider
//   div_divisor    latched operand for the divider
//   div_quotient   divider result, sampled in CAPTURE
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DIV_LATENCY = 11,
    parameter int unsigned ID_W        = 2
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [16*N_REQ-1:0]   req_dividend,
    input  logic [16*N_REQ-1:0]   req_divisor,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [QUOT_W-1:0]     resp_quotient,
    output logic                  busy,
    output logic                  div_en,
    output logic [OPND_W-1:0]     div_dividend,
    output logic [OPND_W-1:0]     div_divisor,
    input  logic [QUOT_W-1:0]     div_quotient
);

    localparam int unsigned      CNT_W    = $clog2(DIV_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

    div_arb_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [OPND_W-1:0] dividend_q, dividend_d;
    logic [OPND_W-1:0] divisor_q, divisor_d;
    logic              zero_q, zero_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic [OPND_W-1:0] sel_dividend;
    logic [OPND_W-1:0] sel_divisor;

    divider_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    // {id, 4'b0} == id * 16
    assign sel_dividend = req_dividend[{pick_id, 4'b0000} +: OPND_W];
    assign sel_divisor  = req_divisor[{pick_id, 4'b0000} +: OPND_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        zero_d     = zero_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ptr_d      = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
                    id_d       = pick_id;
                    dividend_d = sel_dividend;
                    divisor_d  = sel_divisor;
                    zero_d     = (sel_divisor == '0);
                    // A zero divisor bypasses the divider; CAPTURE then returns DIV_ZERO_Q
                    state_d    = (sel_divisor == '0) ? CAPTURE : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            id_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            zero_q     <= zero_d;
        end
    end

    assign req_ready     = (state_q == IDLE) ? pick_grant : '0;
    assign busy          = (state_q != IDLE);
    assign div_en        = (state_q == ISSUE);
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign resp_valid    = (state_q == CAPTURE);
    assign resp_id       = (state_q == CAPTURE) ? id_q : '0;
    assign resp_quotient = (state_q == CAPTURE) ? (zero_q ? DIV_ZERO_Q : div_quotient) : '0;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter with a behavioural stand-in for the shared sequential divider.
module tb_divider_arbiter;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned DIV_LATENCY = 11;
    localparam int unsigned ID_W        = 2;

    logic                clk = 1'b0;
    logic                nRst = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [16*N_REQ-1:0] req_dividend = '0;
    logic [16*N_REQ-1:0] req_divisor = '0;
    logic [N_REQ-1:0]    req_ready;
    logic                resp_valid;
    logic [ID_W-1:0]     resp_id;
    logic [7:0]          resp_quotient;
    logic                busy;
    logic                div_en;
    logic [15:0]         div_dividend;
    logic [15:0]         div_divisor;
    logic [7:0]          div_quotient;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    always #5 clk = ~clk;

    divider_arbiter #(
        .N_REQ       (N_REQ),
        .DIV_LATENCY (DIV_LATENCY),
        .ID_W        (ID_W)
    ) dut (
        .clk           (clk),
        .nRst          (nRst),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_quotient (resp_quotient),
        .busy          (busy),
        .div_en        (div_en),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient)
    );

    function automatic logic [7:0] ref_q(input logic [15:0] a, input logic [15:0] b);
        int unsigned num;
        if (b == 16'd0) return 8'hFF;
        num = 32'(a) << 8;
        return 8'(num / 32'(b));
    endfunction

    // Divider stand-in: output is garbage until DIV_LATENCY cycles after the en cycle
    logic [7:0] res_q;
    int         dcnt;
    always @(posedge clk) begin
        if (nRst) begin
            div_quotient <= 8'h00;
            res_q        <= 8'h00;
            dcnt         <= 0;
        end else if (div_en) begin
            res_q        <= ref_q(div_dividend, div_divisor);
            div_quotient <= ~ref_q(div_dividend, div_divisor);
            dcnt         <= DIV_LATENCY - 1;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) div_quotient <= res_q;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] dvd, input logic [15:0] dvs);
        req_valid[i]              = 1'b1;
        req_dividend[i*16 +: 16]  = dvd;
        req_divisor[i*16 +: 16]   = dvs;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        nRst = 1'b0;
        #1;
        mptr = 0;
    endtask

    // Serve the next grant: the expected winner comes from the model pointer
    task automatic serve_one(input string tag);
        int          exp_g;
        int          n;
        int          en_cnt;
        int          lat;
        bit          done;
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [7:0]  exp_q;
        #1;
        exp_g = -1;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(mptr + k) % N_REQ]) exp_g = (mptr + k) % N_REQ;
        end
        if (exp_g < 0) return;
        n = 0;
        while (req_ready == '0 && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_grant"}, 64'(req_ready), 64'(1) << exp_g);
        if (req_ready == '0) return;
        dvd   = req_dividend[exp_g*16 +: 16];
        dvs   = req_divisor[exp_g*16 +: 16];
        exp_q = (dvs == 16'd0) ? 8'hFF : ref_q(dvd, dvs);
        lat   = (dvs == 16'd0) ? 1 : DIV_LATENCY + 2;
        @(posedge clk);
        #1;
        req_valid[exp_g] = 1'b0;
        mptr   = (exp_g + 1) % N_REQ;
        en_cnt = 0;
        n      = 0;
        done   = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            #1;
            n++;
            if (n == 1) chk({tag, "_operands"}, {div_dividend, div_divisor}, {dvd, dvs});
            if (div_en) en_cnt++;
            if (resp_valid) begin
                done = 1;
                chk({tag, "_latency"}, 64'(n), 64'(lat));
                chk({tag, "_quotient"}, resp_quotient, exp_q);
                chk({tag, "_id"}, resp_id, exp_g);
                chk({tag, "_div_en_count"}, en_cnt, (dvs == 16'd0) ? 0 : 1);
                chk({tag, "_no_grant_at_resp"}, {busy, req_ready}, {1'b1, 4'b0000});
            end else begin
                chk({tag, "_busy_no_grant"}, {busy, req_ready}, {1'b1, 4'b0000});
            end
        end
        if (!done) chk({tag, "_resp_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        int resp_cnt;
        logic [15:0] dvs;
        repeat (2) @(negedge clk);
        nRst = 1'b0;
        #1;

        // Reset state
        chk("rst_ready", req_ready, 0);
        chk("rst_resp", {resp_valid, resp_id, resp_quotient}, 0);
        chk("rst_busy_en", {busy, div_en}, 0);
        chk("rst_operands", {div_dividend, div_divisor}, 0);

        // 1: single req 0, 1/4
        set_req(0, 16'd1, 16'd4);
        serve_one("t1");
        // 2: req 2, 3/4
        set_req(2, 16'd3, 16'd4);
        serve_one("t2");

        // 3: all four at once from reset, then pointer wraps back to 0
        do_reset();
        set_req(0, 16'd1, 16'd3);
        set_req(1, 16'd5, 16'd7);
        set_req(2, 16'd100, 16'd1000);
        set_req(3, 16'd7, 16'd8);
        repeat (4) serve_one("t3");
        set_req(1, 16'd2, 16'd9);
        set_req(0, 16'd9, 16'd10);
        repeat (2) serve_one("t3_wrap");

        // 4: zero divisor
        set_req(1, 16'd5, 16'd0);
        serve_one("t4");

        // 5: fairness after grant, order 3,0,3
        set_req(3, 16'd1, 16'd5);
        set_req(0, 16'd2, 16'd5);
        serve_one("t5_a");
        set_req(3, 16'd3, 16'd5);
        serve_one("t5_b");
        serve_one("t5_c");

        // 6: reset during WAIT aborts the request
        set_req(0, 16'd1, 16'd4);
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (5) @(negedge clk);
        #1;
        chk("t6_busy_mid", busy, 1'b1);
        do_reset();
        chk("t6_rst_outputs", {req_ready, resp_valid, busy, div_en, div_dividend, div_divisor}, 0);
        resp_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (resp_valid) resp_cnt++;
        end
        chk("t6_no_resp", resp_cnt, 0);
        set_req(0, 16'd1, 16'd2);
        serve_one("t6_after");

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            int mask;
            mask = $urandom_range(1, 15);
            for (int i = 0; i < N_REQ; i++) begin
                if (mask[i]) begin
                    dvs = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
                    set_req(i, (dvs == 16'd0) ? 16'($urandom) : 16'($urandom % dvs), dvs);
                end
            end
            n = 0;
            while (req_valid != '0 && n < 8) begin
                serve_one("rnd");
                n++;
            end
            req_valid = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
